// File: rtl/mrd_mem_pkt.sv
// Shared definitions for the mixed-radix DFT memory engine: phase codes
// driven on the fsm bus and the per-stage radix list type.
package mrd_mem_pkt;

  typedef enum logic [2:0] {
    Idle        = 3'd0,
    Sink        = 3'd1,
    Wait_to_rd  = 3'd2,
    Rd          = 3'd3,
    Wait_wr_end = 3'd4,
    Source      = 3'd5
  } phase_e;

  // Radix per butterfly stage, entry 0 first; a 0 entry terminates the list.
  typedef logic [0:5][2:0] nf_t;

  localparam int unsigned NF_STAGES = 6;
  localparam logic [15:0] WDOG_MAX  = 16'hFFFF;

endpackage

// File: rtl/mrd_nf_stage_cnt.sv
// Counts the leading nonzero radix entries of an Nf list (0..6).
module mrd_nf_stage_cnt
  import mrd_mem_pkt::*;
(
  input  nf_t        nf,
  output logic [2:0] nstg
);

  logic run;

  // Count entries until the first zero radix terminates the list.
  always_comb begin
    nstg = '0;
    run  = 1'b1;
    for (int unsigned i = 0; i < NF_STAGES; i++) begin
      if (run && (nf[i] != 3'd0)) begin
        nstg = nstg + 3'd1;
      end else begin
        run = 1'b0;
      end
    end
  end

endmodule

// File: rtl/mrd_fsm_ctrl_p2.sv
// Phase sequencer for the mixed-radix DFT memory engine: Sink, one Rd /
// Wait_wr_end pass per radix stage, then Source.
// Optional watchdog on the waiting phases: define MRD_FSM_WDOG_EN.
module mrd_fsm_ctrl_p2
  import mrd_mem_pkt::*;
#(
  parameter int unsigned WAIT_RD_CYC = 4,
  parameter int unsigned W_PTS       = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sink_valid,
  input  logic             sink_sop,
  input  logic             sink_eop,
  output logic             sink_ready,
  input  nf_t              Nf,
  input  logic [W_PTS-1:0] dftpts,
  input  logic             rd_end,
  input  logic             wr_end,
  input  logic             source_end,
  output logic [2:0]       fsm,
  output logic [2:0]       fsm_r,
  output logic [2:0]       stage_idx,
  output nf_t              Nf_lat,
  output logic [W_PTS-1:0] dftpts_lat,
`ifdef MRD_FSM_WDOG_EN
  output logic             wdog_to,
`endif
  output logic             frame_done,
  output logic             len_err,
  output logic             cfg_err
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_RD_CYC - 1);

  phase_e           state, state_nxt;
  logic [W_PTS-1:0] pts_cnt, pts_inc;
  logic [3:0]       wait_cnt;
  logic [2:0]       nstg_in, nstg_lat;
  logic             latch_cfg, pts_step, stage_inc;
  logic             len_err_nxt, cfg_err_nxt, done_nxt;

`ifdef MRD_FSM_WDOG_EN
  logic [15:0]      wdog_cnt;
  logic             wdog_run, wdog_fire;
`endif

  mrd_nf_stage_cnt u_nf_stage_cnt (
    .nf   (Nf),
    .nstg (nstg_in)
  );

  assign fsm        = state;
  assign sink_ready = (state == Idle) || (state == Sink);
  assign pts_inc    = pts_cnt + W_PTS'(1);

  // Next-phase decode and per-cycle control strobes.
  always_comb begin
    state_nxt   = state;
    latch_cfg   = 1'b0;
    pts_step    = 1'b0;
    stage_inc   = 1'b0;
    len_err_nxt = 1'b0;
    cfg_err_nxt = 1'b0;
    done_nxt    = 1'b0;
    case (state)
      Idle: begin
        if (sink_valid && sink_sop) begin
          if (Nf[0] == 3'd0) begin
            cfg_err_nxt = 1'b1;
          end else begin
            latch_cfg = 1'b1;
            if (!sink_eop) begin
              state_nxt = Sink;
            end else if (dftpts == W_PTS'(1)) begin
              state_nxt = Wait_to_rd;
            end else begin
              len_err_nxt = 1'b1;
            end
          end
        end
      end
      Sink: begin
        if (sink_valid) begin
          pts_step = 1'b1;
          if (sink_eop) begin
            if (pts_inc == dftpts_lat) begin
              state_nxt = Wait_to_rd;
            end else begin
              len_err_nxt = 1'b1;
              state_nxt   = Idle;
            end
          end
        end
      end
      Wait_to_rd: begin
        if (wait_cnt == WAIT_LAST) state_nxt = Rd;
      end
      Rd: begin
        if (rd_end) state_nxt = Wait_wr_end;
      end
      Wait_wr_end: begin
        if (wr_end) begin
          if (stage_idx == nstg_lat - 3'd1) begin
            state_nxt = Source;
          end else begin
            stage_inc = 1'b1;
            state_nxt = Rd;
          end
        end
      end
      Source: begin
        if (source_end) begin
          state_nxt = Idle;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = Idle;
    endcase
`ifdef MRD_FSM_WDOG_EN
    // Watchdog timeout overrides whatever the phase decode chose.
    if (wdog_fire) begin
      state_nxt = Idle;
      stage_inc = 1'b0;
      done_nxt  = 1'b0;
    end
`endif
  end

`ifdef MRD_FSM_WDOG_EN
  assign wdog_run  = (state == Rd) || (state == Wait_wr_end) || (state == Source);
  assign wdog_fire = wdog_run && (wdog_cnt == WDOG_MAX);

  // Watchdog counter: restarts on every phase change, idles outside waiting phases.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wdog_cnt <= '0;
      wdog_to  <= 1'b0;
    end else begin
      wdog_to <= wdog_fire;
      if (!wdog_run || (state_nxt != state)) wdog_cnt <= '0;
      else                                   wdog_cnt <= wdog_cnt + 16'd1;
    end
  end
`endif

  // Phase register, delayed copy, counters, latched config and pulse outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= Idle;
      fsm_r      <= Idle;
      pts_cnt    <= '0;
      wait_cnt   <= '0;
      stage_idx  <= '0;
      nstg_lat   <= '0;
      Nf_lat     <= '0;
      dftpts_lat <= '0;
      frame_done <= 1'b0;
      len_err    <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      fsm_r      <= state;
      frame_done <= done_nxt;
      len_err    <= len_err_nxt;
      cfg_err    <= cfg_err_nxt;

      if (latch_cfg) begin
        Nf_lat     <= Nf;
        dftpts_lat <= dftpts;
        nstg_lat   <= nstg_in;
        pts_cnt    <= W_PTS'(1);
      end else if (pts_step) begin
        pts_cnt <= pts_inc;
      end

      if (state == Wait_to_rd) wait_cnt <= wait_cnt + 4'd1;
      else                     wait_cnt <= '0;

      // Stage index restarts both on the way into Rd and on return to Idle.
      if ((state_nxt == Idle) || (state == Wait_to_rd)) stage_idx <= '0;
      else if (stage_inc)                               stage_idx <= stage_idx + 3'd1;
    end
  end

endmodule

// File: tb/tb_mrd_fsm_ctrl_p2.sv
// Directed self-checking bench for mrd_fsm_ctrl_p2 (WAIT_RD_CYC=4, W_PTS=12).
module tb_mrd_fsm_ctrl_p2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              sink_valid, sink_sop, sink_eop;
  logic              sink_ready;
  logic [0:5][2:0]   nf;
  logic [11:0]       dftpts;
  logic              rd_end, wr_end, source_end;
  logic [2:0]        fsm, fsm_r, stage_idx;
  logic [0:5][2:0]   nf_lat;
  logic [11:0]       dftpts_lat;
  logic              frame_done, len_err, cfg_err;
`ifdef MRD_FSM_WDOG_EN
  logic              wdog_to;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mrd_fsm_ctrl_p2 #(.WAIT_RD_CYC(4), .W_PTS(12)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sink_valid (sink_valid),
    .sink_sop   (sink_sop),
    .sink_eop   (sink_eop),
    .sink_ready (sink_ready),
    .Nf         (nf),
    .dftpts     (dftpts),
    .rd_end     (rd_end),
    .wr_end     (wr_end),
    .source_end (source_end),
    .fsm        (fsm),
    .fsm_r      (fsm_r),
    .stage_idx  (stage_idx),
    .Nf_lat     (nf_lat),
    .dftpts_lat (dftpts_lat),
`ifdef MRD_FSM_WDOG_EN
    .wdog_to    (wdog_to),
`endif
    .frame_done (frame_done),
    .len_err    (len_err),
    .cfg_err    (cfg_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sends samples 0..eop_at with sop on the first and eop on the last.
  task automatic send_frame(input int eop_at);
    for (int i = 0; i <= eop_at; i++) begin
      sink_valid = 1'b1;
      sink_sop   = (i == 0);
      sink_eop   = (i == eop_at);
      tick();
      if (i < eop_at) chk("sink_fsm", 32'(fsm), 32'd1);
    end
    sink_valid = 1'b0;
    sink_sop   = 1'b0;
    sink_eop   = 1'b0;
  endtask

  // Four observed cycles in Wait_to_rd, then Rd at stage 0.
  task automatic wait_rd();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wait_fsm", 32'(fsm), 32'd2);
    end
    tick();
    chk("rd_entry_fsm", 32'(fsm), 32'd3);
    chk("rd_entry_stage", 32'(stage_idx), 32'd0);
  endtask

  task automatic pulse(input int which);
    rd_end     = (which == 0);
    wr_end     = (which == 1);
    source_end = (which == 2);
    tick();
    rd_end     = 1'b0;
    wr_end     = 1'b0;
    source_end = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; sink_valid = 1'b0; sink_sop = 1'b0; sink_eop = 1'b0;
    rd_end = 1'b0; wr_end = 1'b0; source_end = 1'b0;
    nf = {3'd4, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
    dftpts = 12'd12;
    tick(); tick();
    chk("rst_fsm", 32'(fsm), 32'd0);
    chk("rst_fsm_r", 32'(fsm_r), 32'd0);
    chk("rst_stage", 32'(stage_idx), 32'd0);
    chk("rst_nf_lat", 32'(nf_lat), 32'd0);
    chk("rst_dftpts_lat", 32'(dftpts_lat), 32'd0);
    chk("rst_pulses", {29'd0, frame_done, len_err, cfg_err}, 32'd0);
    chk("rst_ready", 32'(sink_ready), 32'd1);
    rst_n = 1'b1;

    // Stray engine pulses in Idle do nothing.
    rd_end = 1'b1; wr_end = 1'b1; source_end = 1'b1;
    tick();
    rd_end = 1'b0; wr_end = 1'b0; source_end = 1'b0;
    chk("stray_idle_fsm", 32'(fsm), 32'd0);
    chk("stray_idle_done", 32'(frame_done), 32'd0);

    // Two-stage frame {4,3}, 12 points.
    sink_valid = 1'b1; sink_sop = 1'b1;
    tick();
    chk("sop_fsm", 32'(fsm), 32'd1);
    chk("sop_fsm_r", 32'(fsm_r), 32'd0);
    chk("nf_lat", 32'(nf_lat), 32'(18'o430000));
    chk("dftpts_lat", 32'(dftpts_lat), 32'd12);
    chk("sink_ready_in_sink", 32'(sink_ready), 32'd1);
    sink_sop = 1'b0; rd_end = 1'b1; wr_end = 1'b1;
    for (int i = 1; i < 11; i++) begin
      sink_sop = (i == 5);
      tick();
      rd_end = 1'b0; wr_end = 1'b0;
      chk("sink_hold", 32'(fsm), 32'd1);
    end
    chk("sink_fsm_r", 32'(fsm_r), 32'd1);
    sink_sop = 1'b0; sink_eop = 1'b1;
    tick();
    sink_valid = 1'b0; sink_eop = 1'b0;
    chk("eop_fsm", 32'(fsm), 32'd2);
    chk("wait_ready", 32'(sink_ready), 32'd0);
    wait_rd();
    chk("rd_fsm_r", 32'(fsm_r), 32'd2);
    tick();
    chk("rd_hold", 32'(fsm), 32'd3);
    rd_end = 1'b1; wr_end = 1'b1;
    tick();
    rd_end = 1'b0; wr_end = 1'b0;
    chk("rd_wr_both_fsm", 32'(fsm), 32'd4);
    tick();
    chk("wr_dropped_fsm", 32'(fsm), 32'd4);
    chk("wr_dropped_stage", 32'(stage_idx), 32'd0);
    pulse(1);
    chk("stage1_fsm", 32'(fsm), 32'd3);
    chk("stage1_idx", 32'(stage_idx), 32'd1);
    chk("stage1_fsm_r", 32'(fsm_r), 32'd4);
    pulse(0);
    chk("stage1_wait_fsm", 32'(fsm), 32'd4);
    pulse(1);
    chk("source_fsm", 32'(fsm), 32'd5);
    chk("source_stage", 32'(stage_idx), 32'd1);
    tick();
    chk("source_hold", 32'(fsm), 32'd5);
    pulse(2);
    chk("done_fsm", 32'(fsm), 32'd0);
    chk("done_pulse", 32'(frame_done), 32'd1);
    chk("done_stage", 32'(stage_idx), 32'd0);
    chk("done_fsm_r", 32'(fsm_r), 32'd5);
    tick();
    chk("done_clear", 32'(frame_done), 32'd0);

    // Short frame: eop on 11th sample.
    send_frame(10);
    chk("short_fsm", 32'(fsm), 32'd0);
    chk("short_len_err", 32'(len_err), 32'd1);
    tick();
    chk("short_no_rd", 32'(fsm), 32'd0);
    chk("short_len_err_clr", 32'(len_err), 32'd0);

    // Single-cycle sop+eop with dftpts != 1 is a length error.
    dftpts = 12'd5;
    send_frame(0);
    chk("sop_eop_bad_fsm", 32'(fsm), 32'd0);
    chk("sop_eop_bad_err", 32'(len_err), 32'd1);

    // Zero first radix.
    nf = '0;
    sink_valid = 1'b1; sink_sop = 1'b1;
    tick();
    sink_valid = 1'b0; sink_sop = 1'b0;
    chk("cfg_fsm", 32'(fsm), 32'd0);
    chk("cfg_err", 32'(cfg_err), 32'd1);
    chk("cfg_ready", 32'(sink_ready), 32'd1);
    tick();
    chk("cfg_err_clr", 32'(cfg_err), 32'd0);

    // One-point frame goes straight to Wait_to_rd, single stage.
    nf = {3'd5, 3'd0, 3'd4, 3'd0, 3'd0, 3'd0};
    dftpts = 12'd1;
    send_frame(0);
    chk("one_pt_fsm", 32'(fsm), 32'd2);
    wait_rd();
    pulse(0);
    pulse(1);
    chk("one_stage_source", 32'(fsm), 32'd5);
    pulse(2);
    chk("one_stage_done", 32'(frame_done), 32'd1);

    // Six stages of radix 2, 64 points.
    nf = {3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2};
    dftpts = 12'd64;
    send_frame(63);
    chk("six_eop_fsm", 32'(fsm), 32'd2);
    wait_rd();
    for (int s = 0; s < 6; s++) begin
      chk("six_rd_fsm", 32'(fsm), 32'd3);
      chk("six_rd_stage", 32'(stage_idx), 32'(s));
      pulse(0);
      chk("six_wait_fsm", 32'(fsm), 32'd4);
      pulse(1);
    end
    chk("six_source_fsm", 32'(fsm), 32'd5);
    chk("six_source_stage", 32'(stage_idx), 32'd5);
    pulse(2);
    chk("six_done", 32'(frame_done), 32'd1);

    // Reset while in Wait_wr_end at stage 1.
    nf = {3'd4, 3'd3, 3'd0, 3'd0, 3'd0, 3'd0};
    dftpts = 12'd12;
    send_frame(11);
    wait_rd();
    pulse(0);
    pulse(1);
    pulse(0);
    chk("pre_rst_fsm", 32'(fsm), 32'd4);
    chk("pre_rst_stage", 32'(stage_idx), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mid_rst_fsm", 32'(fsm), 32'd0);
    chk("mid_rst_stage", 32'(stage_idx), 32'd0);
    tick();
    chk("mid_rst_fsm_r", 32'(fsm_r), 32'd0);

`ifdef MRD_FSM_WDOG_EN
    // Rd with rd_end withheld times out.
    send_frame(11);
    wait_rd();
    repeat (65535) tick();
    chk("wdog_hold_fsm", 32'(fsm), 32'd3);
    chk("wdog_hold_to", 32'(wdog_to), 32'd0);
    tick();
    chk("wdog_fsm", 32'(fsm), 32'd0);
    chk("wdog_to", 32'(wdog_to), 32'd1);
    tick();
    chk("wdog_to_clr", 32'(wdog_to), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
